bus_demux3_32bit: RTL and testbench
===================================

// Module: bus_demux3_32bit
// PURPOSE
//  Registered 1-to-3 bus distributor. This is the receive-side counterpart
//  of the 3:1 32-bit bus select mux.
//  - Takes one source word plus a 2-bit select.
//  - Steers the word into one of three destination holding registers: D, B or E.
//  - Each destination has its own valid/ready handshake.
//  - A stalled destination blocks only words addressed to that destination.
// PARAMETERS
//  WIDTH  32  data width of input and every destination channel
//  CNT_W  8   width of per-channel transfer counters (only with BUS_DEMUX_CNT_EN)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset_n    in   1      asynchronous reset, active-low
//  in_data    in   WIDTH  source word
//  in_sel     in   2      destination select, decoded below
//  in_valid   in   1      source word present
//  in_ready   out  1      word accepted this cycle when in_valid & in_ready
//  d_data     out  WIDTH  channel D word
//  d_valid    out  1      channel D holds a word
//  d_ready    in   1      channel D sink accepts
//  b_data     out  WIDTH  channel B word
//  b_valid    out  1      channel B holds a word
//  b_ready    in   1      channel B sink accepts
//  e_data     out  WIDTH  channel E word
//  e_valid    out  1      channel E holds a word
//  e_ready    in   1      channel E sink accepts
//  d_cnt, b_cnt, e_cnt  out  CNT_W  completed transfers per channel (BUS_DEMUX_CNT_EN only)
// BEHAVIOUR
//  - Select decode, the inverse of the mux:
//    - in_sel[1]=1, in_sel[0]=0 -> D
//    - in_sel=2'b11 -> B
//    - in_sel[1]=0 -> E (in_sel[0] ignored)
//  - Each channel is a one-entry register (data + valid); there is no other storage.
//  - in_ready is combinational: ~t_valid | t_ready, where t is the decoded target.
//    - Depends only on in_sel and the target channel state.
//    - Never depends on in_valid.
//  - Accept (in_valid & in_ready) into channel t:
//    - t_data <= in_data, t_valid <= 1.
//    - Latency is one cycle: the word is visible on t_* the cycle after accept.
//  - Drain: when t_valid & t_ready and there is no accept to t, t_valid <= 0.
//    t_data holds its last value.
//  - Simultaneous drain and accept on the same channel: valid stays 1 and data
//    is replaced. Full throughput is 1 word/clk per channel.
//  - While t_valid=1 and t_ready=0: t_data is stable and t_valid stays 1.
//    No word is ever dropped or overwritten.
//  - Channels are independent. A stall on one channel does not alter another
//    channel's valid or data.
//  - in_sel or in_data changes while in_valid=1 and not accepted are legal.
//    Routing uses the values present in the accept cycle.
//  - No data path is combinational from in_* to any *_data or *_valid output.
//  - Reset (async assert, any time, including mid-transfer):
//    - All *_valid = 0, all *_data = 0, counters = 0.
//    - Held words are discarded.
//    - in_ready = 1 while reset is deasserted and no channel is full.
//  - Deassertion is sampled on the next clk edge. The first accept is possible
//    in the first cycle after deassertion.
// CONFIGURATION
//  - Macro BUS_DEMUX_CNT_EN: when defined, d_cnt, b_cnt and e_cnt exist.
//    - Each counter increments by 1 on every output handshake (t_valid & t_ready)
//      of its channel.
//    - Each counter wraps 2^CNT_W-1 -> 0 and resets to 0.
//  - When undefined, the counter ports and logic are absent.
//    Data-path behaviour is identical in both builds.
// TESTING
//  1. Reset, then in_sel=2'b10, in_data=32'hDEAD_BEEF, one valid beat, d_ready=1
//     -> d_valid=1 and d_data=DEADBEEF the next cycle, high for one cycle;
//     b_valid and e_valid stay 0.
//  2. d_ready=0, send two D words (A1, A2)
//     -> A1 accepted, in_ready=0 for A2, d_data holds A1.
//     Raise d_ready -> A1 consumed, A2 accepted the same cycle, A2 appears the next cycle.
//  3. D stalled with a held word; send in_sel=2'b11 word 0x5 and in_sel=2'b01 word 0x7
//     -> both accepted back to back; b_data=5 and e_data=7; D word unchanged.
//  4. All readies=1, stream 8 words alternating D/B/E
//     -> in_ready constantly 1, each word on the correct channel 1 cycle later, no loss.
//  5. Assert reset_n=0 mid-stream with all three channels full
//     -> all valids and data 0 immediately (asynchronously, no clock).
//     After release, the first word routes normally.
//  6. BUS_DEMUX_CNT_EN, CNT_W=8: 257 D handshakes -> d_cnt=1; b_cnt=e_cnt=0.

Source files
------------

// File: rtl/bus_demux3_32bit.sv
// Registered 1-to-3 bus distributor: one source word steered into channel D, B or E.
// Optional per-channel transfer counters are built when BUS_DEMUX_CNT_EN is defined.
module bus_demux3_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d_data,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] e_data,
  output logic             e_valid,
  input  logic             e_ready
`ifdef BUS_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] b_cnt,
  output logic [CNT_W-1:0] e_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("bus_demux3_32bit: WIDTH and CNT_W must be at least 1");
  end

  // Channel index order everywhere below: 0 = D, 1 = B, 2 = E.
  logic [2:0]            hit;
  logic [2:0]            acc;
  logic [2:0]            ch_ready;
  logic [2:0]            ch_valid;
  logic [2:0][WIDTH-1:0] ch_data;

  // Handshake rule on every port: a word moves on a rising edge where
  // valid & ready are both 1; valid never waits on ready, and in_ready is a
  // pure function of in_sel and the addressed channel (never of in_valid).
  always_comb begin
    hit    = 3'b000;
    hit[0] = (in_sel == 2'b10);
    hit[1] = (in_sel == 2'b11);
    hit[2] = ~in_sel[1];
  end

  assign ch_ready = {e_ready, b_ready, d_ready};
  assign in_ready = |(hit & (~ch_valid | ch_ready));
  assign acc      = hit & {3{in_valid & in_ready}};

  for (genvar i = 0; i < 3; i++) begin : g_ch
    // Accept wins over drain so a same-cycle drain+accept keeps valid high.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ch_valid[i] <= 1'b0;
        ch_data[i]  <= '0;
      end else if (acc[i]) begin
        ch_valid[i] <= 1'b1;
        ch_data[i]  <= in_data;
      end else if (ch_ready[i]) begin
        ch_valid[i] <= 1'b0;
      end
    end
  end

  assign d_valid = ch_valid[0];
  assign b_valid = ch_valid[1];
  assign e_valid = ch_valid[2];
  assign d_data  = ch_data[0];
  assign b_data  = ch_data[1];
  assign e_data  = ch_data[2];

`ifdef BUS_DEMUX_CNT_EN
  logic [2:0][CNT_W-1:0] cnt;

  for (genvar i = 0; i < 3; i++) begin : g_cnt
    // Counts completed output handshakes; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt[i] <= '0;
      end else if (ch_valid[i] && ch_ready[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  assign d_cnt = cnt[0];
  assign b_cnt = cnt[1];
  assign e_cnt = cnt[2];
`endif

endmodule

// File: tb/tb_bus_demux3_32bit.sv
// Randomized and directed bench for bus_demux3_32bit against a queue-based model
// of pending words; counter checks are included when BUS_DEMUX_CNT_EN is defined.
module tb_bus_demux3_32bit;

  localparam int W     = 32;
  localparam int CNT_W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_sel = 2'b00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] d_data, b_data, e_data;
  logic         d_valid, b_valid, e_valid;
  logic         d_ready = 1'b0, b_ready = 1'b0, e_ready = 1'b0;
`ifdef BUS_DEMUX_CNT_EN
  logic [CNT_W-1:0] d_cnt, b_cnt, e_cnt;
`endif

  bus_demux3_32bit #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .e_data(e_data), .e_valid(e_valid), .e_ready(e_ready)
`ifdef BUS_DEMUX_CNT_EN
    , .d_cnt(d_cnt), .b_cnt(b_cnt), .e_cnt(e_cnt)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [2:0]   obs_valid;
  logic [W-1:0] obs_data [3];
  assign obs_valid   = {e_valid, b_valid, d_valid};
  assign obs_data[0] = d_data;
  assign obs_data[1] = b_data;
  assign obs_data[2] = e_data;

  // scoreboard: words held by the DUT, tagged {channel, word}
  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_word [3];
  int           hs_cnt [3];
  int           total_cnt = 0;
  int           bad_cnt = 0;
  string        ch_name [3] = '{"d", "b", "e"};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int target_of(input logic [1:0] s);
    if (s == 2'b10) return 0;
    if (s == 2'b11) return 1;
    return 2;
  endfunction

  function automatic int find_ch(input int c);
    foreach (exp_q[i]) if (int'(exp_q[i][W+1:W]) == c) return i;
    return -1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      last_word[c] = '0;
      hs_cnt[c]    = 0;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < 3; c++) begin
      int idx;
      idx = find_ch(c);
      check_eq($sformatf("%s_valid", ch_name[c]), 64'(obs_valid[c]), 64'(idx >= 0));
      check_eq($sformatf("%s_data", ch_name[c]), 64'(obs_data[c]),
               64'((idx >= 0) ? exp_q[idx][W-1:0] : last_word[c]));
    end
`ifdef BUS_DEMUX_CNT_EN
    check_eq("d_cnt", 64'(d_cnt), 64'(hs_cnt[0] % (1 << CNT_W)));
    check_eq("b_cnt", 64'(b_cnt), 64'(hs_cnt[1] % (1 << CNT_W)));
    check_eq("e_cnt", 64'(e_cnt), 64'(hs_cnt[2] % (1 << CNT_W)));
`endif
  endtask

  // driver: called on a falling edge, runs one full clock, returns on the next falling edge
  task automatic step(input logic v, input logic [1:0] s, input logic [W-1:0] dat,
                      input logic [2:0] rdy);
    int   t;
    logic exp_rdy;
    in_valid = v;
    in_sel   = s;
    in_data  = dat;
    d_ready  = rdy[0];
    b_ready  = rdy[1];
    e_ready  = rdy[2];
    #1;
    t       = target_of(s);
    exp_rdy = (find_ch(t) < 0) || rdy[t];
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      int idx;
      idx = find_ch(c);
      if (idx >= 0 && rdy[c]) begin
        exp_q.delete(idx);
        hs_cnt[c]++;
      end
    end
    if (v && exp_rdy) begin
      exp_q.push_back({t[1:0], dat});
      last_word[t] = dat;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // asynchronous reset pulse landing between clock edges; outputs must clear with no edge
  task automatic apply_reset();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      check_eq($sformatf("rst_%s_valid", ch_name[c]), 64'(obs_valid[c]), 64'd0);
      check_eq($sformatf("rst_%s_data", ch_name[c]), 64'(obs_data[c]), 64'd0);
    end
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    model_clear();
    @(negedge clk);
    apply_reset();

    // single D beat, visible one cycle later for one cycle
    step(1'b1, 2'b10, 32'hDEAD_BEEF, 3'b111);
    step(1'b0, 2'b10, 32'h0, 3'b111);

    // D stalled: second word refused until the first drains
    step(1'b1, 2'b10, 32'hA1, 3'b110);
    step(1'b1, 2'b10, 32'hA2, 3'b110);
    step(1'b1, 2'b10, 32'hA2, 3'b111);
    step(1'b0, 2'b10, 32'h0, 3'b110);
    step(1'b0, 2'b10, 32'h0, 3'b111);

    // D held while B and E keep flowing
    step(1'b1, 2'b10, 32'hC0DE_0001, 3'b000);
    step(1'b1, 2'b11, 32'h5, 3'b000);
    step(1'b1, 2'b01, 32'h7, 3'b000);
    step(1'b1, 2'b00, 32'h9, 3'b000);
    step(1'b0, 2'b00, 32'h0, 3'b111);

    // back-to-back stream over all three channels
    for (int i = 0; i < 8; i++) begin
      logic [1:0] s;
      s = (i % 3 == 0) ? 2'b10 : (i % 3 == 1) ? 2'b11 : 2'(i & 1);
      step(1'b1, s, $urandom, 3'b111);
    end
    step(1'b0, 2'b10, 32'h0, 3'b111);

    // all channels full, then reset mid-stream
    step(1'b1, 2'b10, 32'h1111_1111, 3'b000);
    step(1'b1, 2'b11, 32'h2222_2222, 3'b000);
    step(1'b1, 2'b00, 32'h3333_3333, 3'b000);
    apply_reset();
    step(1'b1, 2'b11, 32'h4444_4444, 3'b111);
    step(1'b0, 2'b11, 32'h0, 3'b111);

    // random traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rdy;
      for (int c = 0; c < 3; c++) rdy[c] = ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, rdy);
    end

`ifdef BUS_DEMUX_CNT_EN
    apply_reset();
    for (int i = 0; i < 257; i++) step(1'b1, 2'b10, $urandom, 3'b111);
    step(1'b0, 2'b10, 32'h0, 3'b111);
    check_eq("d_cnt_wrap", 64'(d_cnt), 64'd1);
    check_eq("b_cnt_idle", 64'(b_cnt), 64'd0);
    check_eq("e_cnt_idle", 64'(e_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
